// File: rtl/dram_port_arbiter_pkg.sv
// Shared types for the SDRAM command-port arbiter.
// Command bundle and requester index constants.
package dram_port_arbiter_pkg;

  localparam int DRAM_ADDR_W = 25;
  localparam int DRAM_DATA_W = 16;
  localparam int DRAM_BE_W   = DRAM_DATA_W / 8;

  localparam int DRAM_PORT_VGA  = 0;
  localparam int DRAM_PORT_CPU  = 1;
  localparam int DRAM_PORT_UART = 2;

  typedef struct packed {
    logic                   we;
    logic [DRAM_ADDR_W-1:0] addr;
    logic [DRAM_DATA_W-1:0] wdata;
    logic [DRAM_BE_W-1:0]   be;
  } dram_req_t;

endpackage

// File: rtl/dram_port_arbiter_tag_fifo.sv
// Tag FIFO recording which requester issued each outstanding read.
// First-word-fall-through head; fullness comes from the registered count.
module tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;
  logic [PW:0]   cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/dram_port_arbiter.sv
// SDRAM command-port arbiter: port 0 priority with a starvation bound,
// round-robin among the rest, read responses routed back by tag.
module dram_port_arbiter
  import dram_port_arbiter_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int MAX_OUT  = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  dram_req_t              req [NREQ],
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DRAM_DATA_W-1:0] rsp_data,
  output logic                   mem_valid,
  input  logic                   mem_ready,
  output dram_req_t              mem_req,
  input  logic                   mem_rvalid,
  input  logic [DRAM_DATA_W-1:0] mem_rdata,
  output logic                   err_orphan
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(HOLD_MAX + 1);

  logic [IW-1:0]          rr_q, rr_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   mem_valid_q, mem_valid_d;
  dram_req_t              mem_req_q, mem_req_d;
  logic [NREQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [DRAM_DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                   err_q, err_d;

  logic            tag_full, tag_empty;
  logic            tag_push, tag_pop;
  logic [IW-1:0]   tag_head;
  logic [NREQ-1:0] elig;
  logic            slot_free, others_elig, others_valid;
  logic            hold_lock, found, accept;
  logic [IW-1:0]   win;
  int              j;

  assign slot_free = !mem_valid_q || mem_ready;

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_valid[i] && (req[i].we || !tag_full);
  end

  assign others_elig  = |elig[NREQ-1:1];
  assign others_valid = |req_valid[NREQ-1:1];
  assign hold_lock    = (hold_q == HW'(HOLD_MAX)) && others_elig;

  // Port 0 first unless it has used up its run; else scan from rr_q.
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    if (elig[0] && !hold_lock) begin
      found = 1'b1;
    end else begin
      for (int k = 0; k < NREQ - 1; k++) begin
        j = int'(rr_q) + k;
        if (j > NREQ - 1) j = j - (NREQ - 1);
        if (!found && elig[j]) begin
          found = 1'b1;
          win   = IW'(j);
        end
      end
    end
    accept    = found && slot_free && rst_;
    req_ready = '0;
    if (accept) req_ready[win] = 1'b1;
  end

  always_comb begin
    rr_d        = rr_q;
    hold_d      = hold_q;
    mem_valid_d = mem_valid_q;
    mem_req_d   = mem_req_q;
    if (accept && win != '0)
      rr_d = (win == IW'(NREQ - 1)) ? IW'(1) : win + 1'b1;
    if (!others_valid)
      hold_d = '0;
    else if (accept)
      hold_d = (win != '0) ? '0 :
               (hold_q == HW'(HOLD_MAX)) ? hold_q : hold_q + 1'b1;
    if (slot_free) begin
      mem_valid_d = accept;
      if (accept) mem_req_d = req[win];
    end
  end

  assign tag_push = accept && !req[win].we;
  assign tag_pop  = mem_rvalid && !tag_empty;

  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (tag_pop) begin
      rsp_valid_d[tag_head] = 1'b1;
      rsp_data_d            = mem_rdata;
    end
    err_d = err_q || (mem_rvalid && tag_empty);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rr_q        <= IW'(1);
      hold_q      <= '0;
      mem_valid_q <= 1'b0;
      mem_req_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      hold_q      <= hold_d;
      mem_valid_q <= mem_valid_d;
      mem_req_q   <= mem_req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  tag_fifo #(
    .W     (IW),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_        (rst_),
    .push_i      (tag_push),
    .push_data_i (win),
    .pop_i       (tag_pop),
    .head_o      (tag_head),
    .full_o      (tag_full),
    .empty_o     (tag_empty)
  );

  assign mem_valid  = mem_valid_q;
  assign mem_req    = mem_req_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign err_orphan = err_q;

endmodule
